pipe_hazard_ctl: RTL and testbench
==================================

Name: pipe_hazard_ctl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Detects RAW hazards between the D-stage instruction and producers in E and M, using Tuse/Tnew timing.
- Tracks the multi-cycle mult/div unit and stalls HI/LO consumers while it is busy.
- Drives the freeze of PC/Dreg and the clear input of Ereg; keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MUL_LAT, 5, busy cycles for mult/multu (must be >= 1).
- DIV_LAT, 10, busy cycles for div/divu (must be >= 1).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- Pctl_clk_i  in  1  pipeline clock; all state updates on its rising edge.
- Pctl_rstn_i  in  1  reset, asynchronous, active-low.
- Pctl_rs_D_i  in  5  rs index of the D-stage instruction.
- Pctl_rt_D_i  in  5  rt index of the D-stage instruction.
- Pctl_tuse_rs_D_i  in  2  cycles until rs is needed (3 = not used).
- Pctl_tuse_rt_D_i  in  2  cycles until rt is needed (3 = not used).
- Pctl_mdu_D_i  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- Pctl_dst_E_i  in  5  destination register of the E-stage instruction (0 = none).
- Pctl_tnew_E_i  in  2  cycles until the E-stage result is ready.
- Pctl_dst_M_i  in  5  destination register of the M-stage instruction.
- Pctl_tnew_M_i  in  2  cycles until the M-stage result is ready.
- Pctl_start_E_i  in  1  mult/div issuing in E this cycle.
- Pctl_isdiv_E_i  in  1  qualifies start: 1 = div, 0 = mult.
- Pctl_stall_o  out  1  freeze PC and Dreg.
- Pctl_clr_E_o  out  1  clear Ereg (insert bubble).
- Pctl_busy_o  out  1  mult/div unit busy.
- Pctl_done_o  out  1  one-cycle pulse when mult/div completes.
- Pctl_stallcnt_o  out  CNT_W  total stall cycles since reset.

Behaviour:
- Reset (Pctl_rstn_i=0, asynchronous): FSM=IDLE, latency counter=0.
  - Outputs: busy_o=0, done_o=0, stallcnt_o=0.
  - stall_o and clr_E_o are 0 unless driven by the combinational hazard terms.
  - Reset mid-operation aborts any mult/div with no done pulse.
- RAW stall (combinational): for src in {rs,rt}, hazard if src!=0 and either
  - src==dst_E and tnew_E > tuse_src, or
  - src==dst_M and tnew_M > tuse_src.
  - Register 0 never stalls.
  - tuse=3 never stalls, because tnew is at most 2.
- MDU stall (combinational): mdu_D and (busy_o or start_E).
- stall_o = RAW stall OR MDU stall.
- clr_E_o = stall_o, same cycle. No other flush source.
- FSM states: IDLE, BUSY.
  - IDLE: on an edge with start_E=1, load cnt = (isdiv ? DIV_LAT : MUL_LAT) - 1 and go to BUSY.
  - BUSY: each edge, cnt decrements. On an edge with cnt==0, go to IDLE and set the registered done_o=1 for exactly the following cycle.
  - busy_o = (state==BUSY), registered.
  - Result: busy_o is high for exactly LAT cycles, starting the cycle after the start edge; done_o is high the cycle busy_o falls.
- start_E while BUSY is ignored: count is unchanged and no restart. The MDU stall prevents this in legal flow.
- Stall counter: increments on each edge where stall_o=1. It saturates at all-ones and does not wrap.
- No output depends on inputs except stall_o and clr_E_o.

Test Plan:
- Load-use: M-side lw with dst_E=8, tnew_E=2; D uses rs=8, tuse_rs=0 -> stall_o=clr_E_o=1. Next cycle (dst_M=8, tnew_M=1) still stalls. When tnew_M=0, no stall. stallcnt_o=2.
- Zero register: dst_E=0, tnew_E=2, rs_D=0, tuse=0 -> stall_o=0. Same case with tuse_rs=3 and rs=5=dst_E -> stall_o=0.
- Mult: start_E=1, isdiv=0 at edge 0 -> busy_o=1 in cycles 1-5, done_o=1 only in cycle 6. With mdu_D=1 throughout, stall_o=1 in cycles 0-5.
- Div with DIV_LAT=10 -> busy_o high for 10 cycles, a single done pulse. A start_E pulse in busy cycle 3 changes neither duration nor done timing.
- Reset in busy cycle 2 -> busy_o=0 and stallcnt_o=0 immediately (asynchronous); no done pulse. A fresh mult after release gives a full 5-cycle busy.
- Saturation with CNT_W=4: hold a stall for 20 cycles -> stallcnt_o reaches 15 and stays at 15.

Source files
------------

// File: rtl/pipe_hazard_ctl.sv
// Pipeline stall/flush controller: RAW hazard detection from Tuse/Tnew, mult/div
// busy tracking, and a saturating stall-cycle counter for performance debug.
module pipe_hazard_ctl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 16
) (
    input  logic             Pctl_clk_i,
    input  logic             Pctl_rstn_i,
    input  logic [4:0]       Pctl_rs_D_i,
    input  logic [4:0]       Pctl_rt_D_i,
    input  logic [1:0]       Pctl_tuse_rs_D_i,
    input  logic [1:0]       Pctl_tuse_rt_D_i,
    input  logic             Pctl_mdu_D_i,
    input  logic [4:0]       Pctl_dst_E_i,
    input  logic [1:0]       Pctl_tnew_E_i,
    input  logic [4:0]       Pctl_dst_M_i,
    input  logic [1:0]       Pctl_tnew_M_i,
    input  logic             Pctl_start_E_i,
    input  logic             Pctl_isdiv_E_i,
    output logic             Pctl_stall_o,
    output logic             Pctl_clr_E_o,
    output logic             Pctl_busy_o,
    output logic             Pctl_done_o,
    output logic [CNT_W-1:0] Pctl_stallcnt_o
);

    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int LAT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // state_q and cnt_q are the FSM's observable state for external checkers.
    state_t             state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   stallcnt_q;

    logic               raw_stall;
    logic               mdu_stall;

    // A source stalls only when its producer's result arrives later than it is needed.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] dst_e,
        input logic [1:0] tnew_e,
        input logic [4:0] dst_m,
        input logic [1:0] tnew_m
    );
        logic hit;
        hit = 1'b0;
        if (src != 5'd0) begin
            if ((src == dst_e) && (tnew_e > tuse)) hit = 1'b1;
            if ((src == dst_m) && (tnew_m > tuse)) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        raw_stall = src_hazard(Pctl_rs_D_i, Pctl_tuse_rs_D_i, Pctl_dst_E_i,
                               Pctl_tnew_E_i, Pctl_dst_M_i, Pctl_tnew_M_i)
                  | src_hazard(Pctl_rt_D_i, Pctl_tuse_rt_D_i, Pctl_dst_E_i,
                               Pctl_tnew_E_i, Pctl_dst_M_i, Pctl_tnew_M_i);
        // A start in E counts as busy so the next HI/LO access cannot slip past it.
        mdu_stall = Pctl_mdu_D_i & ((state_q == BUSY) | Pctl_start_E_i);
    end

    assign Pctl_stall_o = raw_stall | mdu_stall;
    assign Pctl_clr_E_o = Pctl_stall_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Pctl_start_E_i) begin
                    cnt_d   = Pctl_isdiv_E_i ? LAT_W'(DIV_LAT - 1) : LAT_W'(MUL_LAT - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // start_E is deliberately ignored here; no restart mid-operation.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Pctl_clk_i or negedge Pctl_rstn_i) begin
        if (!Pctl_rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge Pctl_clk_i or negedge Pctl_rstn_i) begin
        if (!Pctl_rstn_i) begin
            stallcnt_q <= '0;
        end else if (Pctl_stall_o && (stallcnt_q != {CNT_W{1'b1}})) begin
            stallcnt_q <= stallcnt_q + CNT_W'(1);
        end
    end

    assign Pctl_busy_o     = (state_q == BUSY);
    assign Pctl_done_o     = done_q;
    assign Pctl_stallcnt_o = stallcnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Bench for pipe_hazard_ctl: directed scenarios plus random traffic, checked
// against a cycle-level reference model (remaining-busy count, total stalls).
module tb_pipe_hazard_ctl;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    // clock / reset
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [4:0]  rs_d, rt_d, dst_e, dst_m;
    logic [1:0]  tuse_rs, tuse_rt, tnew_e, tnew_m;
    logic        mdu_d, start_e, isdiv_e;

    logic        stall16, clr16, busy16, done16;
    logic [15:0] cnt16;
    logic        stall4, clr4, busy4, done4;
    logic [3:0]  cnt4;

    pipe_hazard_ctl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(16)) dut (
        .Pctl_clk_i(clk), .Pctl_rstn_i(rstn),
        .Pctl_rs_D_i(rs_d), .Pctl_rt_D_i(rt_d),
        .Pctl_tuse_rs_D_i(tuse_rs), .Pctl_tuse_rt_D_i(tuse_rt),
        .Pctl_mdu_D_i(mdu_d),
        .Pctl_dst_E_i(dst_e), .Pctl_tnew_E_i(tnew_e),
        .Pctl_dst_M_i(dst_m), .Pctl_tnew_M_i(tnew_m),
        .Pctl_start_E_i(start_e), .Pctl_isdiv_E_i(isdiv_e),
        .Pctl_stall_o(stall16), .Pctl_clr_E_o(clr16),
        .Pctl_busy_o(busy16), .Pctl_done_o(done16),
        .Pctl_stallcnt_o(cnt16)
    );

    pipe_hazard_ctl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut4 (
        .Pctl_clk_i(clk), .Pctl_rstn_i(rstn),
        .Pctl_rs_D_i(rs_d), .Pctl_rt_D_i(rt_d),
        .Pctl_tuse_rs_D_i(tuse_rs), .Pctl_tuse_rt_D_i(tuse_rt),
        .Pctl_mdu_D_i(mdu_d),
        .Pctl_dst_E_i(dst_e), .Pctl_tnew_E_i(tnew_e),
        .Pctl_dst_M_i(dst_m), .Pctl_tnew_M_i(tnew_m),
        .Pctl_start_E_i(start_e), .Pctl_isdiv_E_i(isdiv_e),
        .Pctl_stall_o(stall4), .Pctl_clr_E_o(clr4),
        .Pctl_busy_o(busy4), .Pctl_done_o(done4),
        .Pctl_stallcnt_o(cnt4)
    );

    // reference model state
    int   remain;      // busy cycles still to come
    logic done_m;
    int   total_stalls;
    logic stall_m;

    int checks = 0;
    int errors = 0;
    int busy_seen, done_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic needs_stall();
        logic h;
        h = 1'b0;
        if (rs_d != 0 && ((rs_d == dst_e && tnew_e > tuse_rs) || (rs_d == dst_m && tnew_m > tuse_rs))) h = 1'b1;
        if (rt_d != 0 && ((rt_d == dst_e && tnew_e > tuse_rt) || (rt_d == dst_m && tnew_m > tuse_rt))) h = 1'b1;
        if (mdu_d && (remain > 0 || start_e)) h = 1'b1;
        return h;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        remain       = 0;
        done_m       = 1'b0;
        total_stalls = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ":stall"},   32'(stall16), 32'(stall_m));
        chk({tag, ":clr"},     32'(clr16),   32'(stall_m));
        chk({tag, ":busy"},    32'(busy16),  32'(remain > 0));
        chk({tag, ":done"},    32'(done16),  32'(done_m));
        chk({tag, ":cnt16"},   32'(cnt16),   32'(sat(total_stalls, 65535)));
        chk({tag, ":stall4"},  32'(stall4),  32'(stall_m));
        chk({tag, ":busy4"},   32'(busy4),   32'(remain > 0));
        chk({tag, ":cnt4"},    32'(cnt4),    32'(sat(total_stalls, 15)));
    endtask

    // driver: inputs for the current cycle
    task automatic set_in(input logic [4:0] rs, input logic [1:0] urs,
                          input logic [4:0] rt, input logic [1:0] urt,
                          input logic [4:0] de, input logic [1:0] te,
                          input logic [4:0] dm, input logic [1:0] tm,
                          input logic mdu, input logic st, input logic dv);
        rs_d = rs; tuse_rs = urs; rt_d = rt; tuse_rt = urt;
        dst_e = de; tnew_e = te; dst_m = dm; tnew_m = tm;
        mdu_d = mdu; start_e = st; isdiv_e = dv;
    endtask

    task automatic idle_in();
        set_in(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // one cycle: check mid-cycle, then advance the model across the edge
    task automatic do_cycle(input string tag);
        logic done_next;
        @(negedge clk);
        stall_m = needs_stall();
        check_outputs(tag);
        if (busy16) busy_seen++;
        if (done16) done_seen++;
        @(posedge clk);
        if (rstn) begin
            if (stall_m) total_stalls++;
            done_next = (remain == 1);
            if (remain > 0) remain--;
            else if (start_e) remain = isdiv_e ? DIV_LAT : MUL_LAT;
            done_m = done_next;
        end
        #1;
    endtask

    initial begin
        // reset
        rstn = 1'b0;
        idle_in();
        model_reset();
        #1;
        do_cycle("reset");
        do_cycle("reset");
        rstn = 1'b1;

        // load-use: E then M producer
        set_in(5'd8, 2'd0, 5'd0, 2'd3, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        do_cycle("lu_e");
        set_in(5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 5'd8, 2'd1, 1'b0, 1'b0, 1'b0);
        do_cycle("lu_m");
        set_in(5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 5'd8, 2'd0, 1'b0, 1'b0, 1'b0);
        do_cycle("lu_ok");
        chk("lu_cnt", 32'(cnt16), 32'd2);

        // zero register and tuse=3
        set_in(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd2, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        do_cycle("zero");
        set_in(5'd5, 2'd3, 5'd5, 2'd3, 5'd5, 2'd2, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
        do_cycle("tuse3");
        set_in(5'd0, 2'd3, 5'd9, 2'd1, 5'd0, 2'd0, 5'd9, 2'd2, 1'b0, 1'b0, 1'b0);
        do_cycle("rt_m");

        // mult with mdu consumer waiting
        busy_seen = 0; done_seen = 0;
        set_in(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        do_cycle("mul0");
        start_e = 1'b0;
        for (int i = 1; i <= 7; i++) do_cycle("mul");
        chk("mul_busy_len", 32'(busy_seen), 32'd5);
        chk("mul_done_cnt", 32'(done_seen), 32'd1);

        // div with a stray start in busy cycle 3
        busy_seen = 0; done_seen = 0;
        set_in(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1);
        do_cycle("div0");
        for (int i = 1; i <= 12; i++) begin
            start_e = (i == 3);
            isdiv_e = 1'b0;
            do_cycle("div");
        end
        chk("div_busy_len", 32'(busy_seen), 32'd10);
        chk("div_done_cnt", 32'(done_seen), 32'd1);

        // reset in busy cycle 2 of a mult
        set_in(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        do_cycle("rmul0");
        start_e = 1'b0;
        do_cycle("rmul1");
        rstn = 1'b0;
        #1;
        model_reset();
        chk("rst_busy", 32'(busy16), 32'd0);
        chk("rst_done", 32'(done16), 32'd0);
        chk("rst_cnt16", 32'(cnt16), 32'd0);
        chk("rst_cnt4", 32'(cnt4), 32'd0);
        idle_in();
        busy_seen = 0; done_seen = 0;
        do_cycle("inrst");
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) do_cycle("postrst");
        chk("rst_no_done", 32'(done_seen), 32'd0);

        // fresh mult after release
        busy_seen = 0; done_seen = 0;
        start_e = 1'b1;
        do_cycle("fmul0");
        start_e = 1'b0;
        for (int i = 1; i <= 7; i++) do_cycle("fmul");
        chk("fmul_busy_len", 32'(busy_seen), 32'd5);
        chk("fmul_done_cnt", 32'(done_seen), 32'd1);

        // long stall: 4-bit counter saturates
        set_in(5'd8, 2'd0, 5'd0, 2'd3, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) do_cycle("sat");
        idle_in();
        do_cycle("sat_end");
        chk("sat4", 32'(cnt4), 32'd15);
        chk("sat16", 32'(cnt16), 32'd20);

        // random traffic on a small register set to provoke collisions
        for (int i = 0; i < 400; i++) begin
            set_in(5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                   5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 1)));
            do_cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
